// File: rtl/mmio_bus.sv
// mmio_bus: memory-mapped IO bus between the single-cycle CPU datapath and the
// board peripherals. It muxes load data between data memory and a 32-byte IO
// window and holds the LED/7-segment registers. It also provides switch
// synchronisers, button debouncing and sticky press flags that clear on read.
// Optional feature: define MMIO_TIMER_EN to build the free-running cycle timer
// at offset 0x1C. Without it, that offset reads 0 and ignores writes.
module mmio_bus #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned SW_W         = 8,
    parameter int unsigned BTN_N        = 5,
    parameter int unsigned DEBOUNCE_CYC = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              ioRead,
    input  logic              ioWrite,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       din,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       dout,
    input  logic [SW_W-1:0]   SWITCH,
    input  logic [SW_W-1:0]   switch,
    input  logic [BTN_N-1:0]  button,
    output logic [LED_W-1:0]  LED,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       seg
);

    localparam int unsigned      CNT_W   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    // Word index within the IO window (addr_in[4:2])
    localparam logic [2:0] OFF_LED_BIG = 3'd0;
    localparam logic [2:0] OFF_LED_LIT = 3'd1;
    localparam logic [2:0] OFF_SW_BIG  = 3'd2;
    localparam logic [2:0] OFF_SW_LIT  = 3'd3;
    localparam logic [2:0] OFF_BTN     = 3'd4;
    localparam logic [2:0] OFF_SEG     = 3'd5;
    localparam logic [2:0] OFF_FLAGS   = 3'd6;
`ifdef MMIO_TIMER_EN
    localparam logic [2:0] OFF_TIMER   = 3'd7;
`endif

    // Output and status registers
    logic [LED_W-1:0]            led_big_q, led_big_d;
    logic [LED_W-1:0]            led_lit_q, led_lit_d;
    logic [31:0]                 seg_q, seg_d;
    logic [BTN_N-1:0]            flags_q, flags_d;

    // Synchronisers and debounce state
    logic [SW_W-1:0]             sw_big_s1_q, sw_big_s1_d, sw_big_s2_q, sw_big_s2_d;
    logic [SW_W-1:0]             sw_lit_s1_q, sw_lit_s1_d, sw_lit_s2_q, sw_lit_s2_d;
    logic [BTN_N-1:0]            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [BTN_N-1:0]            btn_stable_q, btn_stable_d;
    logic [BTN_N-1:0][CNT_W-1:0] btn_cnt_q, btn_cnt_d;

`ifdef MMIO_TIMER_EN
    logic [31:0]                 timer_q, timer_d;
`endif

    logic                        in_win_c;
    logic [2:0]                  reg_sel_c;
    logic                        wr_en_c;
    logic                        flag_rd_c;
    logic [31:0]                 io_rdata_c;
    logic                        unused_memwrite_c;

    // MemWrite is only meaningful to the external data memory
    assign unused_memwrite_c = MemWrite;

    assign LED = led_big_q;
    assign led = led_lit_q;
    assign seg = seg_q;

    // Address decode: exact, word-aligned hit inside the 32-byte IO window
    always_comb begin
        in_win_c  = (addr_in[31:5] == BASE_ADDR[31:5]) && (addr_in[1:0] == 2'b00);
        reg_sel_c = addr_in[4:2];
        wr_en_c   = ioWrite && in_win_c;
        // Flags are only consumed (and cleared) when IO data actually reaches dout
        flag_rd_c = ioRead && !MemRead && in_win_c && (reg_sel_c == OFF_FLAGS);
    end

    // IO read mux, zero-extended; unmapped offsets read 0
    always_comb begin
        io_rdata_c = 32'd0;
        if (in_win_c) begin
            case (reg_sel_c)
                OFF_LED_BIG: io_rdata_c = 32'(led_big_q);
                OFF_LED_LIT: io_rdata_c = 32'(led_lit_q);
                OFF_SW_BIG:  io_rdata_c = 32'(sw_big_s2_q);
                OFF_SW_LIT:  io_rdata_c = 32'(sw_lit_s2_q);
                OFF_BTN:     io_rdata_c = 32'(btn_stable_q);
                OFF_SEG:     io_rdata_c = seg_q;
                OFF_FLAGS:   io_rdata_c = 32'(flags_q);
`ifdef MMIO_TIMER_EN
                OFF_TIMER:   io_rdata_c = timer_q;
`endif
                default:     io_rdata_c = 32'd0;
            endcase
        end
    end

    // Load data select: data memory has priority over IO
    always_comb begin
        dout = 32'd0;
        if (MemRead) begin
            dout = mem_rdata;
        end else if (ioRead) begin
            dout = io_rdata_c;
        end
    end

    // Output register writes
    always_comb begin
        led_big_d = led_big_q;
        led_lit_d = led_lit_q;
        seg_d     = seg_q;
        if (wr_en_c) begin
            case (reg_sel_c)
                OFF_LED_BIG: led_big_d = din[LED_W-1:0];
                OFF_LED_LIT: led_lit_d = din[LED_W-1:0];
                OFF_SEG:     seg_d     = din;
                default:     ;
            endcase
        end
    end

    // Synchronisers, per-button debounce counters and sticky press flags
    always_comb begin
        sw_big_s1_d  = SWITCH;
        sw_big_s2_d  = sw_big_s1_q;
        sw_lit_s1_d  = switch;
        sw_lit_s2_d  = sw_lit_s1_q;
        btn_s1_d     = button;
        btn_s2_d     = btn_s1_q;
        btn_stable_d = btn_stable_q;
        btn_cnt_d    = btn_cnt_q;
        for (int i = 0; i < int'(BTN_N); i++) begin
            if (btn_s2_q[i] == btn_stable_q[i]) begin
                btn_cnt_d[i] = '0;
            end else if (btn_cnt_q[i] == CNT_MAX) begin
                btn_stable_d[i] = btn_s2_q[i];
                btn_cnt_d[i]    = '0;
            end else begin
                btn_cnt_d[i] = btn_cnt_q[i] + CNT_W'(1);
            end
        end
        // A new press wins over a same-edge clear so the event is not lost
        flags_d = flags_q;
        if (flag_rd_c) begin
            flags_d = '0;
        end
        flags_d = flags_d | (btn_stable_d & ~btn_stable_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            led_big_q    <= '0;
            led_lit_q    <= '0;
            seg_q        <= '0;
            flags_q      <= '0;
            sw_big_s1_q  <= '0;
            sw_big_s2_q  <= '0;
            sw_lit_s1_q  <= '0;
            sw_lit_s2_q  <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_stable_q <= '0;
            btn_cnt_q    <= '0;
        end else begin
            led_big_q    <= led_big_d;
            led_lit_q    <= led_lit_d;
            seg_q        <= seg_d;
            flags_q      <= flags_d;
            sw_big_s1_q  <= sw_big_s1_d;
            sw_big_s2_q  <= sw_big_s2_d;
            sw_lit_s1_q  <= sw_lit_s1_d;
            sw_lit_s2_q  <= sw_lit_s2_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            btn_stable_q <= btn_stable_d;
            btn_cnt_q    <= btn_cnt_d;
        end
    end

`ifdef MMIO_TIMER_EN
    // Free-running cycle timer; a write loads din and counting continues from it
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wr_en_c && (reg_sel_c == OFF_TIMER)) begin
            timer_d = din + 32'd1;
        end
    end

    // Timer register
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus with a short debounce window.
module tb_mmio_bus;

    localparam int unsigned DEB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF0000;
    localparam int          NV   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, ioRead, ioWrite;
    logic [31:0] addr_in, din, mem_rdata, dout;
    logic [7:0]  SWITCH, switch;
    logic [4:0]  button;
    logic [7:0]  LED, led;
    logic [31:0] seg;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state for the random phase
    logic [7:0]  big_m, lit_m, swb_p1, swb_p2, swl_p1, swl_p2;
    logic [31:0] seg_m;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic        mrd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic [31:0] exp_dout;
        logic [7:0]  exp_big;
        logic [7:0]  exp_lit;
        logic [31:0] exp_seg;
    } vec_t;

    vec_t vecs [NV];

    mmio_bus #(
        .BASE_ADDR    (BASE),
        .LED_W        (8),
        .SW_W         (8),
        .BTN_N        (5),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ioRead    (ioRead),
        .ioWrite   (ioWrite),
        .addr_in   (addr_in),
        .din       (din),
        .mem_rdata (mem_rdata),
        .dout      (dout),
        .SWITCH    (SWITCH),
        .switch    (switch),
        .button    (button),
        .LED       (LED),
        .led       (led),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ioRead    = 1'b0;
        ioWrite   = 1'b0;
        addr_in   = 32'd0;
        din       = 32'd0;
        mem_rdata = 32'd0;
    endtask

    // IO read of one offset; leaves ioRead asserted on that address
    task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
        MemRead = 1'b0;
        ioWrite = 1'b0;
        ioRead  = 1'b1;
        addr_in = BASE + off;
        #1;
        check(name, dout, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        case (a)
            BASE + 32'h00: return {24'd0, big_m};
            BASE + 32'h04: return {24'd0, lit_m};
            BASE + 32'h08: return {24'd0, swb_p2};
            BASE + 32'h0C: return {24'd0, swl_p2};
            BASE + 32'h14: return seg_m;
            default:       return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] alist [10];
        logic [31:0] a;
        logic        wr, rd, mrd;
        logic [31:0] wd, md, exp;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, BASE + 32'h00, 32'h000000A5, 32'h0, 32'h0, 8'hA5, 8'h00, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, BASE + 32'h14, 32'h12345678, 32'h0, 32'h0, 8'hA5, 8'h00, 32'h12345678};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, BASE + 32'h00, 32'h0, 32'h0, 32'hA5, 8'hA5, 8'h00, 32'h12345678};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, BASE + 32'h14, 32'h0, 32'h0, 32'h12345678, 8'hA5, 8'h00, 32'h12345678};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, BASE + 32'h04, 32'hFFFFFF3C, 32'h0, 32'h0, 8'hA5, 8'h3C, 32'h12345678};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, BASE + 32'h01, 32'h77, 32'h0, 32'h0, 8'hA5, 8'h3C, 32'h12345678};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, BASE + 32'h08, 32'h77, 32'h0, 32'h0, 8'hA5, 8'h3C, 32'h12345678};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, BASE + 32'h20, 32'h77, 32'h0, 32'h0, 8'hA5, 8'h3C, 32'h12345678};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'hFFFE0000, 32'h77, 32'h0, 32'h0, 8'hA5, 8'h3C, 32'h12345678};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, BASE + 32'h00, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 8'hA5, 8'h3C, 32'h12345678};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h00000100, 32'h55, 32'h11223344, 32'h11223344, 8'hA5, 8'h3C, 32'h12345678};
        vecs[11] = '{1'b0, 1'b0, 1'b0, BASE + 32'h00, 32'h0, 32'h0, 32'h0, 8'hA5, 8'h3C, 32'h12345678};
        vecs[12] = '{1'b1, 1'b1, 1'b0, BASE + 32'h00, 32'h1FF, 32'h0, 32'hA5, 8'hFF, 8'h3C, 32'h12345678};
        vecs[13] = '{1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'h0, 32'h0, 32'h3C, 8'hFF, 8'h3C, 32'h12345678};
        vecs[14] = '{1'b1, 1'b1, 1'b0, BASE + 32'h10, 32'h77, 32'h0, 32'h0, 8'hFF, 8'h3C, 32'h12345678};
        vecs[15] = '{1'b1, 1'b1, 1'b0, BASE + 32'h18, 32'h77, 32'h0, 32'h0, 8'hFF, 8'h3C, 32'h12345678};

        alist[0] = BASE + 32'h00;
        alist[1] = BASE + 32'h04;
        alist[2] = BASE + 32'h08;
        alist[3] = BASE + 32'h0C;
        alist[4] = BASE + 32'h14;
        alist[5] = BASE + 32'h01;
        alist[6] = BASE + 32'h16;
        alist[7] = BASE + 32'h24;
        alist[8] = 32'hFFFF0100;
        alist[9] = 32'h00001000;

        // Reset with inputs toggling, including IO writes that must not land
        idle();
        rst    = 1'b1;
        SWITCH = 8'h0;
        switch = 8'h0;
        button = 5'h0;
        for (int i = 0; i < 4; i++) begin
            SWITCH  = 8'($urandom);
            switch  = 8'($urandom);
            button  = 5'($urandom);
            ioWrite = 1'b1;
            ioRead  = 1'($urandom);
            addr_in = BASE + 32'(4 * $urandom_range(0, 7));
            din     = $urandom;
            tick();
        end
        idle();
        SWITCH = 8'h0;
        switch = 8'h0;
        button = 5'h0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_LED", 32'(LED), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_seg", seg, 32'h0);
        check("rst_dout_idle", dout, 32'h0);
        rd_check("rst_rd_btn", 32'h10, 32'h0);
        rd_check("rst_rd_flags", 32'h18, 32'h0);
        rd_check("rst_rd_timer", 32'h1C, 32'h0);
        rd_check("rst_rd_sw", 32'h0C, 32'h0);
        tick();
        idle();

        // Table-driven register accesses
        for (int i = 0; i < NV; i++) begin
            ioWrite   = vecs[i].wr;
            ioRead    = vecs[i].rd;
            MemRead   = vecs[i].mrd;
            addr_in   = vecs[i].addr;
            din       = vecs[i].wdata;
            mem_rdata = vecs[i].mdata;
            #1;
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            tick();
            check($sformatf("vec%0d_LED", i), 32'(LED), 32'(vecs[i].exp_big));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_lit));
            check($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
        end
        idle();

        // Switch synchroniser latency
        SWITCH = 8'hA5;
        switch = 8'h3C;
        rd_check("sw_cyc1", 32'h0C, 32'h0);
        tick();
        rd_check("sw_cyc2", 32'h0C, 32'h0);
        tick();
        rd_check("sw_cyc3", 32'h0C, 32'h3C);
        rd_check("sw_big", 32'h08, 32'hA5);
        MemRead   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("memrd_prio", dout, 32'hCAFEF00D);
        idle();
        tick();

        // Short glitch is rejected
        button = 5'b00001;
        for (int i = 0; i < 3; i++) tick();
        button = 5'b00000;
        for (int i = 0; i < 10; i++) tick();
        rd_check("glitch_btn", 32'h10, 32'h0);
        rd_check("glitch_flags", 32'h18, 32'h0);
        tick();
        idle();

        // Held press becomes stable after 2 + DEB edges
        button = 5'b00001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd_check($sformatf("hold_btn_k%0d", k), 32'h10, (k >= 2 + int'(DEB)) ? 32'h1 : 32'h0);
        end
        button = 5'b00000;
        rd_check("flag_rd1", 32'h18, 32'h1);
        tick();
        rd_check("flag_rd2", 32'h18, 32'h0);
        idle();
        for (int i = 0; i < 8; i++) tick();
        rd_check("release_btn", 32'h10, 32'h0);
        rd_check("release_flags", 32'h18, 32'h0);
        tick();
        idle();

        // New press on the same edge as a read-clear of another flag
        button = 5'b00100;
        tick();
        tick();
        button = 5'b00110;
        for (int i = 0; i < 5; i++) tick();
        rd_check("same_btn", 32'h10, 32'h4);
        rd_check("same_flags_old", 32'h18, 32'h4);
        tick();
        rd_check("same_flags_kept", 32'h18, 32'h2);
        tick();
        rd_check("same_btn2", 32'h10, 32'h6);
        rd_check("same_flags_clr", 32'h18, 32'h0);
        idle();
        button = 5'b00000;
        for (int i = 0; i < 10; i++) tick();

        // Reset in the middle of a debounce discards the partial count
        button = 5'b01000;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_LED", 32'(LED), 32'h0);
        check("midrst_seg", seg, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd_check($sformatf("midrst_btn_k%0d", k), 32'h10, (k >= 2 + int'(DEB)) ? 32'h8 : 32'h0);
        end
        button = 5'b00000;
        rd_check("midrst_flags", 32'h18, 32'h8);
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();

        // Cycle timer wrap (or absence)
        ioWrite = 1'b1;
        addr_in = BASE + 32'h1C;
        din     = 32'hFFFFFFFE;
        tick();
        ioWrite = 1'b0;
`ifdef MMIO_TIMER_EN
        rd_check("timer_t1", 32'h1C, 32'hFFFFFFFF);
        tick();
        rd_check("timer_t2", 32'h1C, 32'h00000000);
        tick();
        rd_check("timer_t3", 32'h1C, 32'h00000001);
`else
        rd_check("timer_t1", 32'h1C, 32'h0);
        tick();
        rd_check("timer_t2", 32'h1C, 32'h0);
        tick();
        rd_check("timer_t3", 32'h1C, 32'h0);
`endif
        tick();
        idle();

        // Random accesses against the reference model
        big_m  = 8'h0;
        lit_m  = 8'h0;
        seg_m  = 32'h0;
        swb_p1 = SWITCH;
        swb_p2 = SWITCH;
        swl_p1 = switch;
        swl_p2 = switch;
        for (int n = 0; n < 400; n++) begin
            check($sformatf("rnd%0d_LED", n), 32'(LED), 32'(big_m));
            check($sformatf("rnd%0d_led", n), 32'(led), 32'(lit_m));
            check($sformatf("rnd%0d_seg", n), seg, seg_m);
            a   = alist[$urandom_range(0, 9)];
            wr  = 1'($urandom);
            rd  = 1'($urandom);
            mrd = ($urandom_range(0, 3) == 0);
            wd  = $urandom;
            md  = $urandom;
            SWITCH    = 8'($urandom);
            switch    = 8'($urandom);
            ioWrite   = wr;
            ioRead    = rd;
            MemRead   = mrd;
            addr_in   = a;
            din       = wd;
            mem_rdata = md;
            #1;
            exp = mrd ? md : (rd ? exp_read(a) : 32'h0);
            check($sformatf("rnd%0d_dout", n), dout, exp);
            if (wr) begin
                if (a == BASE + 32'h00) big_m = wd[7:0];
                if (a == BASE + 32'h04) lit_m = wd[7:0];
                if (a == BASE + 32'h14) seg_m = wd;
            end
            swb_p2 = swb_p1;
            swb_p1 = SWITCH;
            swl_p2 = swl_p1;
            swl_p1 = switch;
            tick();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
